ccff_loader: RTL and testbench

CCFF_LOADER -- requirements
Module: ccff_loader

---
 rtl/ccff_loader.sv | 101 ++++++++++
 tb/tb_ccff_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// Serial loader for a configuration flip-flop chain: accepts bitstream bytes,
// shifts CHAIN_LEN bits MSB-first into the chain head and tracks tail parity.
module ccff_loader #(
  parameter int CHAIN_LEN = 128
) (
  input  logic       prog_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       ccff_head,
  output logic       chain_en,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       tail_parity
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int CW     = ($clog2(CHAIN_LEN + 1) > 4) ? $clog2(CHAIN_LEN + 1) : 4;
  localparam int BW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);
  localparam logic [BW-1:0] NB  = BW'(NBYTES);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      shreg;
  logic [3:0]      bits_rem;
  logic [CW-1:0]   shifted;
  logic [BW-1:0]   nbytes_acc;
  logic            parity;
  logic            accept;
  logic [CW-1:0]   remaining;
  logic [3:0]      load_bits;

  always_comb begin
    chain_en  = (state == LOAD) && (bits_rem != 4'd0) && !abort;
    ccff_head = chain_en & shreg[7];
    cfg_ready = (state == LOAD) && (bits_rem <= 4'd1) && (nbytes_acc < NB) && !abort;
    accept    = cfg_valid && cfg_ready;
    // bits_rem is 0 or 1 when a byte is accepted; a pending 1 shifts this cycle
    remaining = LEN - shifted - CW'(bits_rem);
    load_bits = (remaining > CW'(8)) ? 4'd8 : remaining[3:0];
    busy      = (state == LOAD);
    done      = (state == DONE);
    tail_parity = parity;

    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        if (abort)                                  state_nxt = IDLE;
        else if (chain_en && shifted == LEN - CW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bits_rem   <= '0;
      shifted    <= '0;
      nbytes_acc <= '0;
      parity     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        shreg      <= '0;
        bits_rem   <= '0;
        shifted    <= '0;
        nbytes_acc <= '0;
        parity     <= 1'b0;
      end else if (state == LOAD && !abort) begin
        if (chain_en) begin
          parity  <= parity ^ ccff_tail;
          shifted <= shifted + CW'(1);
        end
        // a new byte replaces the register while its predecessor's last bit leaves
        if (accept) begin
          shreg      <= cfg_data;
          bits_rem   <= load_bits;
          nbytes_acc <= nbytes_acc + BW'(1);
        end else if (chain_en) begin
          shreg    <= {shreg[6:0], 1'b0};
          bits_rem <= bits_rem - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with three chain lengths (12, 16, 8) sharing
// clock, reset and data inputs; each instance has its own start.
module tb_ccff_loader;

  logic       clk = 1'b0;
  logic       reset_n, abort, cfg_valid, ccff_tail;
  logic [7:0] cfg_data;
  logic       start [3];
  logic       rdy [3], en [3], head [3], busy [3], done [3], par [3];
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  ccff_loader #(.CHAIN_LEN(12)) u12 (
    .prog_clk(clk), .reset_n(reset_n), .start(start[0]), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy[0]),
    .ccff_head(head[0]), .chain_en(en[0]), .ccff_tail(ccff_tail),
    .busy(busy[0]), .done(done[0]), .tail_parity(par[0]));

  ccff_loader #(.CHAIN_LEN(16)) u16 (
    .prog_clk(clk), .reset_n(reset_n), .start(start[1]), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy[1]),
    .ccff_head(head[1]), .chain_en(en[1]), .ccff_tail(ccff_tail),
    .busy(busy[1]), .done(done[1]), .tail_parity(par[1]));

  ccff_loader #(.CHAIN_LEN(8)) u8 (
    .prog_clk(clk), .reset_n(reset_n), .start(start[2]), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(rdy[2]),
    .ccff_head(head[2]), .chain_en(en[2]), .ccff_tail(ccff_tail),
    .busy(busy[2]), .done(done[2]), .tail_parity(par[2]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start instance s, feed nb bytes (second byte delayed by gap underflow
  // cycles), drive tail from tail_pat, optionally abort after abort_at bits.
  task automatic run_load(input int s, input logic [7:0] b0, input logic [7:0] b1,
                          input int nb, input int gap, input logic [15:0] tail_pat,
                          input int abort_at, input bit hold_start,
                          output int n_en, output logic [15:0] heads, output int n_done,
                          output int rdy_late, output int gap_len, output int lat,
                          output bit timeout);
    int bi;
    int acc_c;
    int en_c;
    bit fin;
    bi = 0; acc_c = -1; en_c = -1; fin = 1'b0;
    n_en = 0; heads = '0; n_done = 0; rdy_late = 0; gap_len = 0;
    cfg_valid = 1'b0; abort = 1'b0;
    start[s] = 1'b1;
    tick;
    if (!hold_start) start[s] = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      cfg_data  = (bi == 0) ? b0 : b1;
      cfg_valid = (bi == 0) || (bi < nb && (gap == 0 || gap_len >= gap - 1));
      abort     = (abort_at >= 0 && n_en == abort_at);
      ccff_tail = (n_en < 16) ? tail_pat[n_en] : 1'b1;
      #1;
      if (done[s]) n_done++;
      if (bi >= nb && rdy[s]) rdy_late++;
      if (en[s]) begin
        if (en_c < 0) en_c = c;
        heads = {heads[14:0], head[s]};
        n_en++;
      end else if (busy[s] && n_en == 8) begin
        gap_len++;
      end
      if (cfg_valid && rdy[s]) begin
        if (acc_c < 0) acc_c = c;
        bi++;
      end
      if (!busy[s]) fin = 1'b1;
      else tick;
    end
    timeout = !fin;
    lat = en_c - acc_c;
    start[s] = 1'b0; cfg_valid = 1'b0; abort = 1'b0; ccff_tail = 1'b0;
  endtask

  int         n_en, n_done, rdy_late, gap_len, lat;
  logic [15:0] heads;
  bit         timeout;

  initial begin
    reset_n = 1'b0; abort = 1'b0; cfg_valid = 1'b0; ccff_tail = 1'b0; cfg_data = '0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    tick; tick;
    check("rst_ready", int'(rdy[0]), 0);
    check("rst_chain_en", int'(en[0]), 0);
    check("rst_head", int'(head[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_parity", int'(par[0]), 0);
    reset_n = 1'b1;
    tick;

    // Back-to-back bytes, 12-bit chain
    run_load(0, 8'hA5, 8'h3C, 2, 0, 16'h0000, -1, 1'b0,
             n_en, heads, n_done, rdy_late, gap_len, lat, timeout);
    check("b2b_timeout", int'(timeout), 0);
    check("b2b_bits", n_en, 12);
    check("b2b_heads", int'(heads[11:0]), 'hA53);
    check("b2b_done", n_done, 1);
    check("b2b_ready_late", rdy_late, 0);
    check("b2b_bubbles", gap_len, 0);
    check("b2b_latency", lat, 1);
    tick;
    check("b2b_idle_busy", int'(busy[0]), 0);
    check("b2b_idle_done", int'(done[0]), 0);
    check("b2b_idle_en", int'(en[0]), 0);

    // 16-bit chain, 4-cycle gap, start held high throughout the load
    run_load(1, 8'h5A, 8'hC3, 2, 4, 16'h0000, -1, 1'b1,
             n_en, heads, n_done, rdy_late, gap_len, lat, timeout);
    check("gap_timeout", int'(timeout), 0);
    check("gap_bits", n_en, 16);
    check("gap_heads", int'(heads), 'h5AC3);
    check("gap_bubbles", gap_len, 4);
    check("gap_done", n_done, 1);

    // 8-bit chain, tail high on bits 1, 4 and 6
    run_load(2, 8'h96, 8'h00, 1, 0, 16'hFF52, -1, 1'b0,
             n_en, heads, n_done, rdy_late, gap_len, lat, timeout);
    check("par_bits", n_en, 8);
    check("par_heads", int'(heads[7:0]), 'h96);
    check("par_done", n_done, 1);
    check("par_at_done", int'(par[2]), 1);
    ccff_tail = 1'b1;
    tick; tick; tick;
    check("par_hold", int'(par[2]), 1);
    check("par_idle_en", int'(en[2]), 0);
    check("par_idle_head", int'(head[2]), 0);
    ccff_tail = 1'b0;
    start[2] = 1'b1;
    tick;
    start[2] = 1'b0;
    check("par_clear", int'(par[2]), 0);
    check("par_restart_busy", int'(busy[2]), 1);

    // Abort after 5 bits, then a full reload
    run_load(0, 8'hA5, 8'h3C, 2, 0, 16'h0000, 5, 1'b0,
             n_en, heads, n_done, rdy_late, gap_len, lat, timeout);
    check("abort_timeout", int'(timeout), 0);
    check("abort_bits", n_en, 5);
    check("abort_heads", int'(heads[4:0]), 'h14);
    check("abort_done", n_done, 0);
    check("abort_busy", int'(busy[0]), 0);
    run_load(0, 8'hA5, 8'h3C, 2, 0, 16'h0000, -1, 1'b0,
             n_en, heads, n_done, rdy_late, gap_len, lat, timeout);
    check("reload_bits", n_en, 12);
    check("reload_heads", int'(heads[11:0]), 'hA53);
    check("reload_done", n_done, 1);
    tick;

    // Asynchronous reset in the middle of a load
    start[1] = 1'b1;
    tick;
    cfg_valid = 1'b1; cfg_data = 8'hFF;
    tick;
    cfg_valid = 1'b0;
    tick;
    check("mid_en", int'(en[1]), 1);
    check("mid_head", int'(head[1]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_en", int'(en[1]), 0);
    check("arst_head", int'(head[1]), 0);
    check("arst_busy", int'(busy[1]), 0);
    check("arst_ready", int'(rdy[1]), 0);
    check("arst_done", int'(done[1]), 0);
    check("arst_par8", int'(par[2]), 0);
    start[1] = 1'b0;
    tick;
    reset_n = 1'b1;
    tick; tick;
    check("post_rst_busy", int'(busy[1]), 0);
    check("post_rst_done", int'(done[1]), 0);
    check("post_rst_en", int'(en[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
